// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, state encoding
// and the instruction classes the sequencer branches on.
package cpu_pkg;

  localparam int OPCODE_W = 5;

  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPCODE_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPCODE_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OPCODE_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OPCODE_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OPCODE_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPCODE_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPCODE_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPCODE_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_HALTED, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU2, CLS_MULDIV, CLS_ALU1, CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } op_class_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the DataPath side (slave).
interface control_sequencer_if #(parameter int IR_W = 32);
  import cpu_pkg::*;

  logic [IR_W-1:0]     IR;
  logic                Start, Stop, Mem_ready;
  logic                PCout, Zlowout, ZHighout, MDRout;
  logic                MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin;
  logic                IncPC, Read;
  logic                Gra, Grb, Grc, Rin, Rout;
  logic [OPCODE_W-1:0] ALU_op;
  logic                Run, Illegal;

  modport master (
    input  IR, Start, Stop, Mem_ready,
    output PCout, Zlowout, ZHighout, MDRout,
           MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin,
           IncPC, Read, Gra, Grb, Grc, Rin, Rout, ALU_op, Run, Illegal
  );

  modport slave (
    output IR, Start, Stop, Mem_ready,
    input  PCout, Zlowout, ZHighout, MDRout,
           MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin,
           IncPC, Read, Gra, Grb, Grc, Rin, Rout, ALU_op, Run, Illegal
  );

endinterface

// File: rtl/control_sequencer_opcode_class.sv
// Combinational opcode-to-class map; the sequencer only ever sees the class.
module opcode_class
  import cpu_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_t           op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL: op_class = CLS_ALU2;
      OP_MUL, OP_DIV:                  op_class = CLS_MULDIV;
      OP_NEG, OP_NOT:                  op_class = CLS_ALU1;
      OP_NOP:                          op_class = CLS_NOP;
      OP_HALT:                         op_class = CLS_HALT;
      default:                         op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state sequencer: fetch, decode IR[31:27] and drive DataPath controls.
// Outputs are a pure decode of the state register and the opcode class.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int IR_W = 32
) (
  input logic                 Clock,
  input logic                 Clear,
  control_sequencer_if.master bus
);

  state_t              state, state_next;
  logic                stop_pending, stop_pending_next;
  logic                last, go_halt;
  logic [OPCODE_W-1:0] opcode;
  op_class_t           op_class;
  logic                unused_ir;

  assign opcode    = bus.IR[IR_W-1 -: OPCODE_W];
  assign unused_ir = ^bus.IR[IR_W-OPCODE_W-1:0];

  opcode_class u_opcode_class (
    .opcode   (opcode),
    .op_class (op_class)
  );

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state        <= ST_HALTED;
      stop_pending <= 1'b0;
    end else begin
      state        <= state_next;
      stop_pending <= stop_pending_next;
    end
  end

  always_comb begin
    state_next   = state;
    last         = 1'b0;
    go_halt      = 1'b0;
    bus.PCout    = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.ZHighout = 1'b0;
    bus.MDRout   = 1'b0;
    bus.MARin    = 1'b0;
    bus.PCin     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.ZLowIn   = 1'b0;
    bus.ZHighIn  = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Read     = 1'b0;
    bus.Gra      = 1'b0;
    bus.Grb      = 1'b0;
    bus.Grc      = 1'b0;
    bus.Rin      = 1'b0;
    bus.Rout     = 1'b0;
    bus.ALU_op   = '0;
    bus.Illegal  = 1'b0;
    bus.Run      = (state != ST_HALTED);

    case (state)
      ST_HALTED: if (bus.Start) state_next = ST_T0;
      ST_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.PCin = 1'b1;
        state_next = ST_T1;
      end
      ST_T1: begin
        bus.Read = 1'b1; bus.MDRin = 1'b1;
        if (bus.Mem_ready) state_next = ST_T2;
      end
      ST_T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
        state_next = ST_T3;
      end
      ST_T3: begin
        case (op_class)
          CLS_ALU2, CLS_MULDIV: begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
            state_next = ST_T4;
          end
          CLS_ALU1: begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.ALU_op = opcode; bus.ZLowIn = 1'b1;
            state_next = ST_T4;
          end
          CLS_HALT:    begin last = 1'b1; go_halt = 1'b1; end
          CLS_ILLEGAL: begin last = 1'b1; bus.Illegal = 1'b1; end
          default:     last = 1'b1;
        endcase
      end
      ST_T4: begin
        if (op_class == CLS_ALU1) begin
          bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
          last = 1'b1;
        end else begin
          bus.Grc = 1'b1; bus.Rout = 1'b1; bus.ALU_op = opcode; bus.ZLowIn = 1'b1;
          bus.ZHighIn = (op_class == CLS_MULDIV);
          state_next = ST_T5;
        end
      end
      ST_T5: begin
        bus.Zlowout = 1'b1;
        if (op_class == CLS_MULDIV) begin
          bus.LOin = 1'b1;
          state_next = ST_T6;
        end else begin
          bus.Gra = 1'b1; bus.Rin = 1'b1;
          last = 1'b1;
        end
      end
      ST_T6: begin
        bus.ZHighout = 1'b1; bus.HIin = 1'b1;
        last = 1'b1;
      end
      default: state_next = ST_HALTED;
    endcase

    // A Stop seen during the final state itself is carried into the next instruction.
    stop_pending_next = stop_pending | bus.Stop;
    if (last) begin
      if (stop_pending || go_halt) begin
        state_next        = ST_HALTED;
        stop_pending_next = 1'b0;
      end else begin
        state_next        = ST_T0;
        stop_pending_next = bus.Stop;
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: a per-instruction control-word table feeds a queue that a
// negedge monitor drains against the live outputs.
module tb_control_sequencer;

  logic Clock = 1'b0;
  logic Clear = 1'b0;

  control_sequencer_if #(.IR_W(32)) bus ();

  control_sequencer #(.IR_W(32)) dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic pc_out, zlo_out, zhi_out, mdr_out;
    logic mar_in, pc_in, mdr_in, ir_in, y_in, zlo_in, zhi_in, hi_in, lo_in;
    logic inc_pc, read;
    logic gra, grb, grc, r_in, r_out;
    logic [4:0] alu_op;
    logic run, illegal;
  } ctl_t;

  typedef struct {
    ctl_t  w;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  ctl_t seq_q[$];
  int   ph_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   halted = 1'b1;
  bit   stop_armed = 1'b0;
  ctl_t dut_w;

  assign dut_w = {bus.PCout, bus.Zlowout, bus.ZHighout, bus.MDRout,
                  bus.MARin, bus.PCin, bus.MDRin, bus.IRin, bus.Yin, bus.ZLowIn,
                  bus.ZHighIn, bus.HIin, bus.LOin, bus.IncPC, bus.Read,
                  bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout,
                  bus.ALU_op, bus.Run, bus.Illegal};

  task automatic checkOutput(input string name, input ctl_t got, input ctl_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput(mon_e.tag, dut_w, mon_e.w);
    end
  end

  function automatic ctl_t running();
    ctl_t c = '0;
    c.run = 1'b1;
    return c;
  endfunction

  function automatic void push(input ctl_t c, input int ph);
    seq_q.push_back(c);
    ph_q.push_back(ph);
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op);
    logic [31:0] r;
    r = $urandom();
    r[31:27] = op;
    return r;
  endfunction

  // Expected control word for every cycle of one instruction, from T0 onward.
  function automatic void build_seq(input logic [4:0] op, input int stalls);
    ctl_t c;
    bit   bin, md;
    seq_q.delete();
    ph_q.delete();
    bin = (op >= 5'd3 && op <= 5'd11);
    md  = (op == 5'd15 || op == 5'd16);
    c = running(); c.pc_out = 1; c.mar_in = 1; c.inc_pc = 1; c.pc_in = 1; push(c, 0);
    c = running(); c.read = 1; c.mdr_in = 1;
    for (int i = 0; i <= stalls; i++) push(c, 1);
    c = running(); c.mdr_out = 1; c.ir_in = 1; push(c, 2);
    if (bin || md) begin
      c = running(); c.grb = 1; c.r_out = 1; c.y_in = 1; push(c, 3);
      c = running(); c.grc = 1; c.r_out = 1; c.alu_op = op; c.zlo_in = 1; c.zhi_in = md; push(c, 4);
      if (md) begin
        c = running(); c.zlo_out = 1; c.lo_in = 1; push(c, 5);
        c = running(); c.zhi_out = 1; c.hi_in = 1; push(c, 6);
      end else begin
        c = running(); c.zlo_out = 1; c.gra = 1; c.r_in = 1; push(c, 5);
      end
    end else if (op == 5'd17 || op == 5'd18) begin
      c = running(); c.grb = 1; c.r_out = 1; c.alu_op = op; c.zlo_in = 1; push(c, 3);
      c = running(); c.zlo_out = 1; c.gra = 1; c.r_in = 1; push(c, 4);
    end else if (op == 5'd26 || op == 5'd27) begin
      push(running(), 3);
    end else begin
      c = running(); c.illegal = 1; push(c, 3);
    end
  endfunction

  task automatic applyStimulus(input ctl_t w, input string tag, input bit start,
                               input bit stop, input bit mr);
    @(posedge Clock);
    #1;
    bus.Start     = start;
    bus.Stop      = stop;
    bus.Mem_ready = mr;
    exp_q.push_back('{w: w, tag: tag});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, "halted idle", 1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic start_cycle(input bit with_stop);
    applyStimulus('0, "halted start", 1'b1, with_stop, 1'($urandom_range(0, 1)));
    stop_armed = with_stop;
    halted     = 1'b0;
  endtask

  // cut >= 0 drives only that many cycles, leaving the instruction in flight.
  task automatic run_instr(input logic [31:0] ir, input int stalls, input int stop_at, input int cut);
    logic [4:0] op;
    int         stop_idx, t1_seen, n;
    bit         mr;
    op = ir[31:27];
    build_seq(op, stalls);
    stop_idx = stop_at;
    if (stop_idx > seq_q.size() - 2) stop_idx = seq_q.size() - 2;
    t1_seen = 0;
    n = (cut >= 0) ? cut : seq_q.size();
    for (int i = 0; i < n; i++) begin
      if (ph_q[i] == 1) begin
        mr = (t1_seen == stalls);
        t1_seen++;
      end else begin
        mr = 1'($urandom_range(0, 1));
      end
      applyStimulus(seq_q[i], $sformatf("op%05b T%0d", op, ph_q[i]),
                    1'($urandom_range(0, 1)), (stop_at >= 0) && (i == stop_idx), mr);
      if (i == 0) bus.IR = ir;
    end
    if (cut < 0) begin
      halted     = (op == 5'd27) || (stop_at >= 0) || stop_armed;
      stop_armed = 1'b0;
    end
  endtask

  initial begin
    bus.IR = '0; bus.Start = 0; bus.Stop = 0; bus.Mem_ready = 0;
    #2 checkOutput("reset comb", dut_w, '0);
    @(posedge Clock); #1 checkOutput("reset held", dut_w, '0);
    #3 Clear = 1'b1;

    idle(2);
    start_cycle(0);
    run_instr(32'h28918000, 0, -1, -1);
    run_instr(mk(5'b00011), 3, -1, -1);
    run_instr(mk(5'b01111), $urandom_range(0, 2), -1, -1);
    run_instr(mk(5'b10000), $urandom_range(0, 2), -1, -1);
    run_instr(mk(5'b11011), 1, -1, -1);
    idle(3);
    start_cycle(0);
    run_instr(mk(5'b00110), 1, 1, -1);
    idle(1);
    start_cycle(0);
    run_instr(mk(5'b11111), 0, -1, -1);
    run_instr(mk(5'b10001), 0, -1, -1);
    run_instr(mk(5'b10010), 1, -1, -1);
    run_instr(mk(5'b11010), 0, -1, -1);
    run_instr(mk(5'b11011), 0, -1, -1);
    idle(1);
    start_cycle(1);
    run_instr(mk(5'b00100), 0, -1, -1);
    idle(2);
    start_cycle(0);

    for (int k = 0; k < 40; k++) begin
      run_instr(mk(5'($urandom_range(0, 31))), $urandom_range(0, 2),
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 8)) : -1, -1);
      if (halted) begin
        idle($urandom_range(0, 2));
        start_cycle($urandom_range(0, 3) == 0);
      end
    end

    // Clear lands while T4 of an and is on the outputs.
    run_instr(mk(5'b00101), 0, -1, 5);
    @(negedge Clock);
    #2;
    Clear = 1'b0; bus.Start = 0; bus.Stop = 0;
    #1 checkOutput("clear mid T4", dut_w, '0);
    @(posedge Clock); #1 checkOutput("clear held", dut_w, '0);
    #2 Clear = 1'b1;
    halted = 1'b1; stop_armed = 1'b0;
    idle(1);
    start_cycle(0);
    run_instr(mk(5'b00101), 1, -1, -1);

    @(negedge Clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL queue drain got=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives the DataPath's control inputs.
- Fetches instructions, decodes IR[31:27], and sequences the T-states for register-format ALU, mul/div, unary, nop and halt instructions.
- Replaces bench-driven control signals; sits directly upstream of DataPath and the select-and-encode logic.

Parameters:
OPCODE_W, 5, width of IR opcode field and ALU_op output
IR_W, 32, instruction register width

Ports:
Clock  in  1  system clock, rising edge
Clear  in  1  asynchronous, active-low reset
IR  in  IR_W  instruction register contents from DataPath
Start  in  1  leave HALTED and begin fetching
Stop  in  1  request halt at next instruction boundary
Mem_ready  in  1  memory read data valid
PCout, Zlowout, ZHighout, MDRout  out  1 each  bus drive enables
MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin  out  1 each  register loads
IncPC, Read  out  1 each  PC increment, memory read
Gra, Grb, Grc, Rin, Rout  out  1 each  select-and-encode controls
ALU_op  out  OPCODE_W  ALU operation code
Run  out  1  high while not HALTED
Illegal  out  1  one-cycle pulse on unsupported opcode

Behaviour:
- Reset and clock:
  - Clock and reset: one clock, Clock; reset Clear is asynchronous and active-low.
  - While Clear=0: state=HALTED, all outputs 0, ALU_op=0, stop_pending=0.
- Output style:
  - Moore-style decode of the state register and IR[31:27]; outputs carry no registered delay.
  - IR is stable from T3 onward.
- States: HALTED, T0, T1, T2, T3, T4, T5, T6. Each state lasts one cycle unless noted.
- HALTED: Run=0. Goes to T0 when Start=1; otherwise stays.
- Fetch:
  - T0: PCout, MARin, IncPC, PCin.
  - T1: Read and MDRin are held while Mem_ready=0 (stall); advance to T2 on the cycle Mem_ready=1.
  - T2: MDRout, IRin.
- Binary ALU (add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, ALU_op=opcode, ZLowIn.
  - T5: Zlowout, Gra, Rin.
  - Then T0.
- mul 01111 / div 10000:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, ALU_op=opcode, ZLowIn, ZHighIn.
  - T5: Zlowout, LOin.
  - T6: ZHighout, HIin.
  - Then T0.
- neg 10001 / not 10010:
  - T3: Grb, Rout, ALU_op=opcode, ZLowIn.
  - T4: Zlowout, Gra, Rin.
  - Then T0.
- nop 11010: T3 asserts nothing, then T0.
- halt 11011: T3 asserts nothing, then HALTED.
- Any other opcode: T3 pulses Illegal=1 for that cycle only, then T0 (executes as nop).
- ALU_op is 0 in every cycle not listed above.
- Stop handling:
  - Stop is sampled every cycle into stop_pending.
  - At an instruction's final state, stop_pending=1 sends the next state to HALTED instead of T0, and stop_pending clears.
  - Stop never aborts a partly executed instruction.
- Start=1 outside HALTED is ignored.
- Start and Stop both high while HALTED: go to T0 and set stop_pending. Exactly one instruction then executes before halting again.
- Reset mid-instruction: immediate return to HALTED with all outputs 0; no partial writeback strobe survives.
- Mutual exclusion: exactly one bus-drive enable (PCout, Zlowout, ZHighout, MDRout, Rout) is high in any state that drives the bus.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams (OP_ADD … OP_HALT)
  - state encoding (ST_HALTED, ST_T0 … ST_T6)
  - OPCODE_W
- One sub-module, opcode_class, combinationally maps opcode to a class: ALU2, MULDIV, ALU1, NOP, HALT, ILLEGAL.
- The sequencer's next-state logic branches on that class only.

Test Plan:
- Reset then Start=1, Mem_ready tied 1, IR=0x28918000 (and) -> states T0..T5 in 6 cycles; T4 ALU_op=00101 with Grc, Rout, ZLowIn; T5 Zlowout, Gra, Rin; then T0.
- Mem_ready held 0 for 3 cycles during T1 -> Read and MDRin stay high 4 cycles total; T2 is entered one cycle after Mem_ready rises.
- IR opcode 01111 (mul) -> T4 asserts ZLowIn and ZHighIn; T5 Zlowout, LOin; T6 ZHighout, HIin; 7 cycles total.
- IR opcode 11011 (halt) -> HALTED after T3, Run=0; Start=1 resumes at T0.
- Stop pulsed during T1 of an or -> instruction completes through T5, then HALTED; opcode 11111 -> Illegal high exactly 1 cycle at T3, then T0.
- Clear driven low during T4 -> all outputs 0 immediately, state HALTED; Clear released, Start -> normal fetch.
